// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IR, IDCODE/BYPASS/user-register DRs and bsc chain strobes.
// Optional: define JTAG_IDCODE_EN to implement the IDCODE instruction and its 32-bit DR.
module jtag_tap_ctrl #(
    parameter int unsigned IR_W            = 3,
    parameter logic [3:0]  VERSION_NUM     = 4'h1,
    parameter logic [15:0] PART_NUM        = 16'hbeef,
    parameter logic [10:0] MANUFACTURER_ID = 11'h6b,
    parameter int unsigned UREG_ADDR_W     = 4,
    parameter int unsigned UREG_DATA_W     = 8
) (
    input  logic                   tck_i,
    input  logic                   trst_i,
    input  logic                   tms_i,
    input  logic                   tdi_i,
    output logic                   tdo_o,
    output logic                   bsc_shift_o,
    output logic                   bsc_capture_o,
    output logic                   bsc_update_o,
    output logic                   bsc_mode_o,
    input  logic                   bsc_tdo_i,
    output logic [UREG_ADDR_W-1:0] ureg_addr_o,
    input  logic [UREG_DATA_W-1:0] ureg_data_i,
    output logic [3:0]             state_o
);

    typedef enum logic [3:0] {
        TLR        = 4'hF,
        RTI        = 4'hC,
        SEL_DR     = 4'h7,
        CAPTURE_DR = 4'h6,
        SHIFT_DR   = 4'h2,
        EXIT1_DR   = 4'h1,
        PAUSE_DR   = 4'h3,
        EXIT2_DR   = 4'h0,
        UPDATE_DR  = 4'h5,
        SEL_IR     = 4'h4,
        CAPTURE_IR = 4'hE,
        SHIFT_IR   = 4'hA,
        EXIT1_IR   = 4'h9,
        PAUSE_IR   = 4'hB,
        EXIT2_IR   = 4'h8,
        UPDATE_IR  = 4'hD
    } tap_state_e;

    localparam logic [IR_W-1:0] IR_EXTEST    = IR_W'(3'b000);
    localparam logic [IR_W-1:0] IR_IDCODE    = IR_W'(3'b001);
    localparam logic [IR_W-1:0] IR_SAMPLE    = IR_W'(3'b010);
    localparam logic [IR_W-1:0] IR_UREG_ADDR = IR_W'(3'b011);
    localparam logic [IR_W-1:0] IR_UREG_DATA = IR_W'(3'b100);
    localparam logic [IR_W-1:0] IR_BYPASS    = '1;
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RESET     = IR_IDCODE;
    localparam logic [31:0]     IDCODE_VAL   = {VERSION_NUM, PART_NUM, MANUFACTURER_ID, 1'b1};
`else
    localparam logic [IR_W-1:0] IR_RESET     = IR_BYPASS;
`endif

    tap_state_e             state, state_nxt;
    logic [IR_W-1:0]        ir, ir_shift;
    logic                   bypass_q;
    logic [UREG_ADDR_W-1:0] ureg_addr_sr;
    logic [UREG_DATA_W-1:0] ureg_data_sr;
    logic                   sel_bsc, sel_idcode, sel_ureg_addr, sel_ureg_data, sel_bypass;
    logic                   idcode_lsb;
    logic                   tdo_dr;

    // Next-state decode of the 16-state TAP machine
    always_comb begin
        state_nxt = state;
        case (state)
            TLR:        state_nxt = tms_i ? TLR       : RTI;
            RTI:        state_nxt = tms_i ? SEL_DR    : RTI;
            SEL_DR:     state_nxt = tms_i ? SEL_IR    : CAPTURE_DR;
            CAPTURE_DR: state_nxt = tms_i ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   state_nxt = tms_i ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   state_nxt = tms_i ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   state_nxt = tms_i ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   state_nxt = tms_i ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  state_nxt = tms_i ? SEL_DR    : RTI;
            SEL_IR:     state_nxt = tms_i ? TLR       : CAPTURE_IR;
            CAPTURE_IR: state_nxt = tms_i ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   state_nxt = tms_i ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   state_nxt = tms_i ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   state_nxt = tms_i ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   state_nxt = tms_i ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  state_nxt = tms_i ? SEL_DR    : RTI;
            default:    state_nxt = TLR;
        endcase
    end

    // Instruction decode; anything unrecognised falls through to BYPASS
    assign sel_bsc       = (ir == IR_EXTEST) || (ir == IR_SAMPLE);
    assign sel_ureg_addr = (ir == IR_UREG_ADDR);
    assign sel_ureg_data = (ir == IR_UREG_DATA);
`ifdef JTAG_IDCODE_EN
    assign sel_idcode    = (ir == IR_IDCODE);
`else
    assign sel_idcode    = 1'b0;
`endif
    assign sel_bypass    = !(sel_bsc || sel_ureg_addr || sel_ureg_data || sel_idcode);

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state        <= TLR;
            ir           <= IR_RESET;
            ir_shift     <= '0;
            bypass_q     <= 1'b0;
            ureg_addr_sr <= '0;
            ureg_data_sr <= '0;
            ureg_addr_o  <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == TLR)
                ir <= IR_RESET;
            else if (state == UPDATE_IR)
                ir <= ir_shift;

            if (state == CAPTURE_IR)
                ir_shift <= IR_W'(2'b01);
            else if (state == SHIFT_IR)
                ir_shift <= {tdi_i, ir_shift[IR_W-1:1]};

            if (state == CAPTURE_DR) begin
                if (sel_bypass)    bypass_q     <= 1'b0;
                if (sel_ureg_addr) ureg_addr_sr <= ureg_addr_o;
                if (sel_ureg_data) ureg_data_sr <= ureg_data_i;
            end else if (state == SHIFT_DR) begin
                if (sel_bypass)    bypass_q     <= tdi_i;
                if (sel_ureg_addr) ureg_addr_sr <= {tdi_i, ureg_addr_sr[UREG_ADDR_W-1:1]};
                if (sel_ureg_data) ureg_data_sr <= {tdi_i, ureg_data_sr[UREG_DATA_W-1:1]};
            end else if (state == UPDATE_DR && sel_ureg_addr) begin
                ureg_addr_o <= ureg_addr_sr;
            end
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_sr;

    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i)
            idcode_sr <= '0;
        else if (state == CAPTURE_DR && sel_idcode)
            idcode_sr <= IDCODE_VAL;
        else if (state == SHIFT_DR && sel_idcode)
            idcode_sr <= {tdi_i, idcode_sr[31:1]};
    end

    assign idcode_lsb = idcode_sr[0];
`else
    assign idcode_lsb = 1'b0;
`endif

    always_comb begin
        tdo_dr = bypass_q;
        if (sel_bsc)            tdo_dr = bsc_tdo_i;
        else if (sel_idcode)    tdo_dr = idcode_lsb;
        else if (sel_ureg_addr) tdo_dr = ureg_addr_sr[0];
        else if (sel_ureg_data) tdo_dr = ureg_data_sr[0];
    end

    // tdo changes on the falling edge so the far end samples it stable on the next rise
    always_ff @(negedge tck_i or posedge trst_i) begin
        if (trst_i)
            tdo_o <= 1'b0;
        else if (state == SHIFT_IR)
            tdo_o <= ir_shift[0];
        else if (state == SHIFT_DR)
            tdo_o <= tdo_dr;
        else
            tdo_o <= 1'b0;
    end

    assign bsc_capture_o = sel_bsc && (state == CAPTURE_DR);
    assign bsc_shift_o   = sel_bsc && (state == SHIFT_DR);
    assign bsc_update_o  = sel_bsc && (state == UPDATE_DR);
    assign bsc_mode_o    = (ir == IR_EXTEST);
    assign state_o       = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: IR/DR scans, bsc strobes, pause, TMS reset and async trst.
module tb_jtag_tap_ctrl;

    localparam int unsigned IR_W = 3;

    logic       tck_i = 1'b0;
    logic       trst_i, tms_i, tdi_i, bsc_tdo_i;
    logic       tdo_o, bsc_shift_o, bsc_capture_o, bsc_update_o, bsc_mode_o;
    logic [3:0] ureg_addr_o;
    logic [7:0] ureg_data_i;
    logic [3:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cap, n_shift, n_upd;
    logic [31:0] got;
    logic [IR_W-1:0] ir_cap;
    logic b;

    jtag_tap_ctrl dut (
        .tck_i(tck_i), .trst_i(trst_i), .tms_i(tms_i), .tdi_i(tdi_i), .tdo_o(tdo_o),
        .bsc_shift_o(bsc_shift_o), .bsc_capture_o(bsc_capture_o), .bsc_update_o(bsc_update_o),
        .bsc_mode_o(bsc_mode_o), .bsc_tdo_i(bsc_tdo_i), .ureg_addr_o(ureg_addr_o),
        .ureg_data_i(ureg_data_i), .state_o(state_o)
    );

    always #5 tck_i = ~tck_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One tck cycle: drive pins, sample outputs after the falling edge, advance past the rising edge
    task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms_i     = tms_v;
        tdi_i     = tdi_v;
        bsc_tdo_i = ~tdi_v;
        @(negedge tck_i);
        #1;
        tdo_v = tdo_o;
        if (bsc_capture_o) n_cap++;
        if (bsc_shift_o)   n_shift++;
        if (bsc_update_o)  n_upd++;
        @(posedge tck_i);
        #1;
    endtask

    // RTI -> IR scan -> RTI
    task automatic shift_ir(input logic [IR_W-1:0] v, output logic [IR_W-1:0] cap);
        logic t;
        step(1'b1, 1'b0, t);
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        for (int i = 0; i < int'(IR_W); i++) begin
            step(i == int'(IR_W) - 1, v[i], t);
            cap[i] = t;
        end
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
    endtask

    // RTI -> DR scan of n bits (optional 3-cycle PAUSE_DR after pause_at bits) -> RTI
    task automatic shift_dr(input logic [31:0] v, input int n, input int pause_at, output logic [31:0] cap);
        logic t;
        cap = '0;
        n_cap = 0; n_shift = 0; n_upd = 0;
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
        step(1'b0, 1'b0, t);
        for (int i = 0; i < n; i++) begin
            step((i == n - 1) || (i == pause_at - 1), v[i], t);
            cap[i] = t;
            if (i == pause_at - 1 && i != n - 1) begin
                step(1'b0, 1'b0, t);
                step(1'b0, 1'b0, t);
                step(1'b0, 1'b0, t);
                step(1'b1, 1'b0, t);
                step(1'b0, 1'b0, t);
            end
        end
        step(1'b1, 1'b0, t);
        step(1'b0, 1'b0, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        trst_i = 1'b1; tms_i = 1'b1; tdi_i = 1'b0; bsc_tdo_i = 1'b0; ureg_data_i = 8'h00;
        #12;
        check_eq("rst_state", 32'(state_o), 32'hF);
        check_eq("rst_tdo", 32'(tdo_o), 32'h0);
        check_eq("rst_ureg_addr", 32'(ureg_addr_o), 32'h0);
        check_eq("rst_mode", 32'(bsc_mode_o), 32'h0);
        check_eq("rst_strobes", 32'({bsc_capture_o, bsc_shift_o, bsc_update_o}), 32'h0);
        trst_i = 1'b0;
        @(posedge tck_i); #1;
        step(1'b0, 1'b0, b);
        check_eq("rti_state", 32'(state_o), 32'hC);

`ifdef JTAG_IDCODE_EN
        shift_dr(32'h0, 32, 0, got);
        check_eq("idcode_after_reset", got, 32'h1BEEF0D7);
`else
        shift_dr(32'hB3, 8, 0, got);
        check_eq("bypass_after_reset", got, 32'h66);
`endif

        // EXTEST: IR capture pattern, mode, strobes and bsc_tdo_i passthrough
        shift_ir(3'b000, ir_cap);
        check_eq("ir_capture", 32'(ir_cap), 32'h1);
        check_eq("extest_mode", 32'(bsc_mode_o), 32'h1);
        shift_dr(32'hC5, 8, 0, got);
        check_eq("extest_tdo", got, 32'h3A);
        check_eq("extest_cap_cnt", 32'(n_cap), 32'd1);
        check_eq("extest_shift_cnt", 32'(n_shift), 32'd8);
        check_eq("extest_upd_cnt", 32'(n_upd), 32'd1);

        shift_ir(3'b010, ir_cap);
        check_eq("sample_mode", 32'(bsc_mode_o), 32'h0);
        shift_dr(32'h0F, 6, 0, got);
        check_eq("sample_tdo", got, 32'h30);
        check_eq("sample_strobes", 32'({n_cap[7:0], n_shift[7:0], n_upd[7:0]}), 32'h010601);

        // User address register
        shift_ir(3'b011, ir_cap);
        shift_dr(32'hA, 4, 0, got);
        check_eq("ureg_addr_cap0", got, 32'h0);
        check_eq("ureg_addr_upd", 32'(ureg_addr_o), 32'hA);
        check_eq("ureg_no_strobes", 32'(n_cap + n_shift + n_upd), 32'd0);
        shift_dr(32'h3, 4, 0, got);
        check_eq("ureg_addr_recap", got, 32'hA);
        check_eq("ureg_addr_upd2", 32'(ureg_addr_o), 32'h3);

        // User data register
        ureg_data_i = 8'h5C;
        shift_ir(3'b100, ir_cap);
        shift_dr(32'hFF, 8, 0, got);
        check_eq("ureg_data_tdo", got, 32'h5C);
        check_eq("ureg_data_no_upd", 32'(ureg_addr_o), 32'h3);

        // Unassigned code 101 behaves as bypass
        shift_ir(3'b101, ir_cap);
        shift_dr(32'hB3, 8, 0, got);
        check_eq("ir101_bypass", got, 32'h66);
        check_eq("ir101_strobes", 32'(n_cap + n_shift + n_upd), 32'd0);
        check_eq("ir101_mode", 32'(bsc_mode_o), 32'h0);

        // Pause in the middle of a data scan
        ureg_data_i = 8'hF0;
        shift_ir(3'b100, ir_cap);
        shift_dr(32'h0, 8, 4, got);
        check_eq("pause_dr_stream", got, 32'hF0);

        // Five TMS=1 cycles from SHIFT_DR reach TLR and restore the reset instruction
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        check_eq("in_shift_dr", 32'(state_o), 32'h2);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b);
        check_eq("tms_reset_state", 32'(state_o), 32'hF);
        step(1'b0, 1'b0, b);
`ifdef JTAG_IDCODE_EN
        shift_dr(32'h0, 32, 0, got);
        check_eq("tms_reset_idcode", got, 32'h1BEEF0D7);
`else
        shift_dr(32'hB3, 8, 0, got);
        check_eq("tms_reset_bypass", got, 32'h66);
`endif

        // Async trst in the middle of an EXTEST data scan
        shift_ir(3'b011, ir_cap);
        shift_dr(32'h5, 4, 0, got);
        shift_ir(3'b000, ir_cap);
        check_eq("pre_trst_mode", 32'(bsc_mode_o), 32'h1);
        check_eq("pre_trst_addr", 32'(ureg_addr_o), 32'h5);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b1, b);
        step(1'b0, 1'b1, b);
        #1 trst_i = 1'b1;
        #1;
        check_eq("trst_mode", 32'(bsc_mode_o), 32'h0);
        check_eq("trst_addr", 32'(ureg_addr_o), 32'h0);
        check_eq("trst_state", 32'(state_o), 32'hF);
        check_eq("trst_shift", 32'(bsc_shift_o), 32'h0);
        check_eq("trst_tdo", 32'(tdo_o), 32'h0);
        trst_i = 1'b0;
        @(posedge tck_i); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller and instruction/data-register sequencer for the boundary-scan chain that wraps the MAC I/O.
- Tracks the 16-state TAP FSM from tms_i and holds the instruction register.
- Generates shift/capture/update/mode strobes for the bsc cells.
- Owns the IDCODE, BYPASS and user-register (ureg address/data) DRs, and muxes tdo.
- Sits between the chip-level JTAG pins and the bsc chain / MAC debug port; all logic runs in the tck domain.

Parameters:
IR_W, 3, instruction register width (minimum 3)
VERSION_NUM, 4'h1, IDCODE[31:28]
PART_NUM, 16'hbeef, IDCODE[27:12]
MANUFACTURER_ID, 11'h6b, IDCODE[11:1]
UREG_ADDR_W, 4, user register address width
UREG_DATA_W, 8, user register data width

Ports:
tck_i  in  1  JTAG test clock; the block's only clock
trst_i  in  1  asynchronous, active-high reset
tms_i  in  1  test mode select
tdi_i  in  1  test data in
tdo_o  out  1  test data out, registered on the falling edge of tck_i
bsc_shift_o  out  1  bsc chain shift enable
bsc_capture_o  out  1  bsc chain capture strobe
bsc_update_o  out  1  bsc chain update strobe
bsc_mode_o  out  1  1 = bsc cells drive the captured/updated value (EXTEST)
bsc_tdo_i  in  1  serial output of the last bsc cell
ureg_addr_o  out  UREG_ADDR_W  user register address for the MAC debug port
ureg_data_i  in  UREG_DATA_W  user register read data from the MAC
state_o  out  4  current TAP state encoding, debug only

Behaviour:
- Clock and reset: one clock, tck_i. Reset trst_i is asynchronous and active-high.
- While trst_i is high:
  - State = TEST_LOGIC_RESET, IR = IDCODE, all shift registers = 0.
  - ureg_addr_o = 0, tdo_o = 0, all bsc_* outputs = 0.
- TAP FSM: standard 16 states, transitions on rising tck_i per 1149.1.
  - Five consecutive tms_i=1 cycles reach TEST_LOGIC_RESET from any state.
  - Entering TEST_LOGIC_RESET synchronously reloads IR to IDCODE.
- Instruction encoding (IR_W=3, upper bits 0 if wider):
  - 000 EXTEST, 001 IDCODE, 010 SAMPLE_PRELOAD, 011 UREG_ADDR, 100 UREG_DATA, 111 BYPASS.
  - Any other code decodes as BYPASS.
- IR path:
  - CAPTURE_IR loads ir_shift = {0..., 2'b01}.
  - SHIFT_IR shifts right, tdi_i into the MSB.
  - UPDATE_IR copies ir_shift into IR on the rising edge.
  - IR is stable in all other states, including PAUSE_IR.
- DR selection by IR:
  - EXTEST / SAMPLE_PRELOAD → bsc chain; serial out is bsc_tdo_i.
  - IDCODE → 32-bit {VERSION_NUM, PART_NUM, MANUFACTURER_ID, 1'b1}, loaded in CAPTURE_DR.
  - BYPASS → 1-bit register, cleared in CAPTURE_DR.
  - UREG_ADDR → UREG_ADDR_W shift register, captures current ureg_addr_o; ureg_addr_o updated in UPDATE_DR.
  - UREG_DATA → UREG_DATA_W shift register, captures ureg_data_i in CAPTURE_DR; UPDATE_DR has no effect.
- Shift rule for internal DRs: shift right in SHIFT_DR, tdi_i into the MSB, LSB out first.
- bsc strobes: combinational decode of the registered state, high for exactly the tck cycle(s) in that state, and only when IR ∈ {EXTEST, SAMPLE_PRELOAD}.
  - bsc_capture_o = CAPTURE_DR.
  - bsc_shift_o = SHIFT_DR.
  - bsc_update_o = UPDATE_DR.
  - All three are 0 for other instructions.
- bsc_mode_o = 1 iff IR == EXTEST. Changes only on UPDATE_IR or reset.
- tdo_o: on the falling tck_i edge, samples the LSB of the active shift register in SHIFT_IR/SHIFT_DR; otherwise drives 0.
- PAUSE_DR/PAUSE_IR: shift registers hold; resuming SHIFT continues with no lost or duplicated bit.
- trst_i asserted mid-shift: partial shift discarded; IR, ureg_addr_o and bsc_mode_o return to reset values immediately.

Optional Feature:
JTAG_IDCODE_EN
- Defined: IDCODE instruction and 32-bit IDCODE DR implemented as above; the reset IR value is IDCODE.
- Undefined: no IDCODE register is synthesized; code 001 decodes as BYPASS; the reset IR value is BYPASS (all ones).

Test Plan:
- Reset then 32 cycles SHIFT_DR with tdi=0 (JTAG_IDCODE_EN defined) → tdo stream LSB-first = 0x1BEEF0D7; JTAG_IDCODE_EN undefined → 0, then tdi delayed by 1 cycle (bypass).
- Load IR=000 → bsc_mode_o=1 after UPDATE_IR; a DR scan pulses bsc_capture_o 1 cycle, bsc_shift_o N cycles, bsc_update_o 1 cycle; tdo equals bsc_tdo_i delayed half a cycle.
- Load IR=011, shift 4'hA, UPDATE_DR → ureg_addr_o=4'hA; load IR=100 with ureg_data_i=8'h5C, shift 8 → tdo stream 0,0,1,1,1,0,1,0.
- SHIFT_IR capture → first two tdo bits 1,0; load IR=101 → behaves as BYPASS (1-cycle delay), bsc_* stay 0.
- From SHIFT_DR, tms=1 for 5 cycles → TEST_LOGIC_RESET, IR=IDCODE; separately, assert trst_i during SHIFT_DR with IR=EXTEST → bsc_mode_o and ureg_addr_o drop to 0 asynchronously.
- Shift 4 bits, PAUSE_DR 3 cycles, shift remaining 4 (UREG_DATA=8'hF0) → full 8-bit sequence intact.
